pipe_stall_ctrl: RTL
====================

// Module: pipe_stall_ctrl
// PURPOSE
//  Producer/consumer partner of the pipeline hazard detector. Tracks destination registers of in-flight
//  instructions (the preWriteReg list the detector compares against) and turns the detector's hazard flag
//  plus branch/jump decode into PC enable, fetch hold, decode bubble and fetch flush. Sits between decode and
//  the IF/PC stage of the RISC-V core.
// PARAMETERS
//  DEPTH      4   in-flight slots tracked (slot 0 = instr just leaving decode, DEPTH-1 = oldest)
//  REG_W      5   register index width
// PORTS
//  clk          in   1            core clock
//  rst          in   1            synchronous, active-high reset
//  idValid      in   1            decode holds a valid instruction
//  idRegWrite   in   1            decode instruction writes a register
//  idWriteReg   in   REG_W        decode destination register
//  idIsBranch   in   1            decode opcode is branch/jal/jalr
//  hazard       in   1            data hazard flag from hazard detector
//  brResolved   in   1            branch outcome valid this cycle (execute)
//  brTaken      in   1            outcome: 1 = taken/jump, qualified by brResolved
//  preWriteReg  out  DEPTH*REG_W  slot i at bits [i*REG_W +: REG_W]; 0 = no pending write
//  pcEnable     out  1            PC may advance/load
//  ifEnable     out  1            IF/ID register may capture
//  idBubble     out  1            replace decode output with NOP
//  flushIF      out  1            kill instruction currently in IF/ID
// BEHAVIOUR
//  Reset: all slots 0, state RUN; while rst=1: pcEnable=0, ifEnable=0, idBubble=1, flushIF=0.
//  Tracker (every cycle, no enable): slot[i] <= slot[i-1] for i>=1; slot[0] <= idWriteReg when
//   accept = idValid & idRegWrite & ~idBubble & idWriteReg!=0, else 0. x0 never recorded.
//  Stall: hazard=1 -> idBubble=1, pcEnable=0, ifEnable=0 same cycle (combinational); older slots keep
//   draining so hazard clears within DEPTH cycles.
//  FSM states RUN, BR_WAIT, BR_REDIRECT:
//   RUN: idValid & idIsBranch & ~hazard -> BR_WAIT; the branch itself passes (not bubbled).
//   BR_WAIT: pcEnable=0, ifEnable=0, idBubble=1. brResolved&brTaken -> BR_REDIRECT;
//    brResolved&~brTaken -> RUN. No timeout; waits indefinitely.
//   BR_REDIRECT (exactly 1 cycle): pcEnable=1 (target load), flushIF=1, ifEnable=1, idBubble=1 -> RUN.
//  Precedence: rst > BR_WAIT/BR_REDIRECT > hazard > normal. hazard with branch in same cycle: branch
//   not accepted until hazard clears. brResolved in RUN ignored. idIsBranch in BR_WAIT ignored.
//  Branch writing a register (jal/jalr) records rd on its accept cycle like any writer.
//  All outputs except preWriteReg are combinational from state/hazard; preWriteReg registered, latency 1.
//  rst mid-BR_WAIT or mid-stall: returns to RUN, slots cleared, next cycle pcEnable=1.
// CONFIGURATION
//  Macro STALL_STATS_EN: defined -> extra outputs stallCycles[31:0] (cycles with idBubble=1, not during
//   rst) and branchStalls[31:0] (RUN->BR_WAIT transitions); both saturate at 2^32-1, cleared by rst.
//  Undefined -> ports and counters absent; remaining behaviour identical.
// STRUCTURE
//  Package hazard_pkg: REG_W, DEPTH defaults, ctrl_state_t enum {RUN, BR_WAIT, BR_REDIRECT}, REG_ZERO.
//  Sub-module dest_shift_reg: DEPTH x REG_W shift register with zero-insert; FSM and output logic at top.
// TESTING
//  1 Reset: rst=1 two cycles -> slots all 0, pcEnable=0, idBubble=1; release -> pcEnable=1, ifEnable=1.
//  2 Tracking: accept rd=5,6,7,8 back-to-back -> after 4 cycles preWriteReg = {5,6,7,8} (slot0=8);
//    rd=0 accept -> slot0=0.
//  3 Data stall: hazard=1 for 2 cycles with rd=9 in decode -> idBubble=1, pcEnable=0, slot0=0 both
//    cycles; hazard drops -> rd=9 recorded next cycle.
//  4 Branch not taken: branch in RUN, brResolved&~brTaken 3 cycles later -> 3 bubble cycles, back in RUN,
//    flushIF never asserted.
//  5 Branch taken: resolve taken -> exactly one cycle pcEnable=1, flushIF=1, then RUN; hazard+branch same
//    cycle -> stays RUN until hazard clears.
//  6 rst asserted in BR_WAIT -> RUN, slots 0; with STALL_STATS_EN counters read 0 after reset.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline stall controller.
package hazard_pkg;

    localparam int unsigned DEF_REG_W = 5;
    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned STAT_W    = 32;

    localparam logic [DEF_REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        BR_WAIT     = 2'd1,
        BR_REDIRECT = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Decode/hazard/fetch-control bundle between the pipeline and pipe_stall_ctrl.
// STALL_STATS_EN adds the stall statistics outputs.
interface pipe_stall_ctrl_if
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned REG_W = DEF_REG_W
);

    logic                   idValid;
    logic                   idRegWrite;
    logic [REG_W-1:0]       idWriteReg;
    logic                   idIsBranch;
    logic                   hazard;
    logic                   brResolved;
    logic                   brTaken;
    logic [DEPTH*REG_W-1:0] preWriteReg;
    logic                   pcEnable;
    logic                   ifEnable;
    logic                   idBubble;
    logic                   flushIF;
`ifdef STALL_STATS_EN
    logic [STAT_W-1:0]      stallCycles;
    logic [STAT_W-1:0]      branchStalls;
`endif

    modport master (
        output idValid, idRegWrite, idWriteReg, idIsBranch, hazard, brResolved, brTaken,
        input  preWriteReg, pcEnable, ifEnable, idBubble, flushIF
`ifdef STALL_STATS_EN
        , input stallCycles, branchStalls
`endif
    );

    modport slave (
        input  idValid, idRegWrite, idWriteReg, idIsBranch, hazard, brResolved, brTaken,
        output preWriteReg, pcEnable, ifEnable, idBubble, flushIF
`ifdef STALL_STATS_EN
        , output stallCycles, branchStalls
`endif
    );

endinterface

// File: rtl/pipe_stall_ctrl_dest_shift_reg.sv
// In-flight destination register tracker: slot 0 newest, slot DEPTH-1 oldest.
module dest_shift_reg
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned REG_W = DEF_REG_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [REG_W-1:0]       i_data,
    output logic [DEPTH*REG_W-1:0] o_slots
);

    logic [DEPTH*REG_W-1:0] r_slots;
    logic [REG_W-1:0]       w_ins;

    // Non-accepted cycles insert an empty slot so older entries keep draining
    always_comb begin
        w_ins = REG_W'(REG_ZERO);
        if (i_load) begin
            w_ins = i_data;
        end
    end

    // Shift every cycle; no enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slots <= '0;
        end else begin
            r_slots <= {r_slots[(DEPTH-1)*REG_W-1:0], w_ins};
        end
    end

    assign o_slots = r_slots;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/branch controller: tracks in-flight writers and drives PC/IF
// enables, decode bubble and fetch flush. Optional macro STALL_STATS_EN adds
// saturating stall and branch-stall counters.
module pipe_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned REG_W = DEF_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
);

    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;
    logic        w_pc_en;
    logic        w_if_en;
    logic        w_bubble;
    logic        w_flush;
    logic        w_br_start;
    logic        w_accept;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and control outputs; reset, then branch states, then hazard
    always_comb begin
        w_state_nxt = r_state;
        w_pc_en     = 1'b1;
        w_if_en     = 1'b1;
        w_bubble    = 1'b0;
        w_flush     = 1'b0;
        w_br_start  = 1'b0;
        if (rst) begin
            w_pc_en  = 1'b0;
            w_if_en  = 1'b0;
            w_bubble = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.hazard) begin
                        w_pc_en  = 1'b0;
                        w_if_en  = 1'b0;
                        w_bubble = 1'b1;
                    end else if (bus.idValid && bus.idIsBranch) begin
                        w_state_nxt = BR_WAIT;
                        w_br_start  = 1'b1;
                    end
                end
                BR_WAIT: begin
                    w_pc_en  = 1'b0;
                    w_if_en  = 1'b0;
                    w_bubble = 1'b1;
                    if (bus.brResolved) begin
                        w_state_nxt = bus.brTaken ? BR_REDIRECT : RUN;
                    end
                end
                BR_REDIRECT: begin
                    w_bubble    = 1'b1;
                    w_flush     = 1'b1;
                    w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    // x0 is never a real dependency, so it is not recorded
    assign w_accept = bus.idValid && bus.idRegWrite && !w_bubble
                      && (bus.idWriteReg != REG_W'(REG_ZERO));

    dest_shift_reg #(
        .DEPTH (DEPTH),
        .REG_W (REG_W)
    ) u_dest_shift_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_data  (bus.idWriteReg),
        .o_slots (bus.preWriteReg)
    );

    assign bus.pcEnable = w_pc_en;
    assign bus.ifEnable = w_if_en;
    assign bus.idBubble = w_bubble;
    assign bus.flushIF  = w_flush;

`ifdef STALL_STATS_EN
    logic [STAT_W-1:0] r_stall_cycles;
    logic [STAT_W-1:0] r_branch_stalls;

    // Saturating bubble-cycle and branch-stall counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles  <= '0;
            r_branch_stalls <= '0;
        end else begin
            if (w_bubble && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + STAT_W'(1);
            end
            if (w_br_start && (r_branch_stalls != '1)) begin
                r_branch_stalls <= r_branch_stalls + STAT_W'(1);
            end
        end
    end

    assign bus.stallCycles  = r_stall_cycles;
    assign bus.branchStalls = r_branch_stalls;
`endif

endmodule
